// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU and DMA requesters share one memory port with a
// bounded CPU burst under DMA contention, plus a 256-cycle whole-memory clear.
module dmem_arbiter #(
  parameter int unsigned CPU_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic       cpu_valid,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic [7:0] dma_rdata,
  output logic       dma_valid,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic       mem_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int unsigned SCW = $clog2(CPU_BURST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]     r_state, w_state_nxt;
  logic           r_cpu_gnt, w_cpu_gnt_nxt;
  logic           r_dma_gnt, w_dma_gnt_nxt;
  logic           r_cpu_valid, r_dma_valid;
  logic [7:0]     r_cpu_rdata, r_dma_rdata;
  logic           r_clr_busy, w_clr_busy_nxt;
  logic [7:0]     r_clr_cnt, w_clr_cnt_nxt;
  logic           r_mem_en, w_mem_en_nxt;
  logic [7:0]     r_mem_addr, w_mem_addr_nxt;
  logic [7:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic [SCW-1:0] r_starve_cnt, w_starve_cnt_nxt;

  logic w_in_clear, w_clr_go, w_starved;
  logic w_cpu_elig, w_dma_elig;
  logic w_gnt_cpu, w_gnt_dma;
  logic w_cpu_rd_ret, w_dma_rd_ret;

  assign w_in_clear = (r_state == ST_CLEAR);
  assign w_clr_go   = clr_start & ~w_in_clear;
  assign w_starved  = (r_starve_cnt == SCW'(CPU_BURST));

  // A port granted this cycle sits out the next edge.
  assign w_cpu_elig = cpu_req & ~r_cpu_gnt;
  assign w_dma_elig = dma_req & ~r_dma_gnt;

  // A non-starved DMA only wins when the CPU is not requesting at all; a CPU
  // sitting out its back-to-back edge leaves an idle slot instead, which keeps
  // the CPU burst intact until the starvation flag forces a DMA turn.
  assign w_gnt_dma = ~w_in_clear & ~clr_start & w_dma_elig & (w_starved | ~cpu_req);
  assign w_gnt_cpu = ~w_in_clear & ~clr_start & w_cpu_elig & ~w_gnt_dma;

  // Read data returns one edge after a read grant, even if a clear starts then.
  assign w_cpu_rd_ret = r_cpu_gnt & ~r_mem_en;
  assign w_dma_rd_ret = r_dma_gnt & ~r_mem_en;

  always_comb begin
    w_state_nxt     = r_state;
    w_cpu_gnt_nxt   = 1'b0;
    w_dma_gnt_nxt   = 1'b0;
    w_clr_busy_nxt  = r_clr_busy;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_mem_en_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    if (w_in_clear) begin
      w_mem_wdata_nxt = 8'h00;
      if (r_clr_cnt == 8'hFF) begin
        w_state_nxt    = ST_IDLE;
        w_clr_busy_nxt = 1'b0;
        w_clr_cnt_nxt  = 8'h00;
      end else begin
        w_clr_cnt_nxt  = r_clr_cnt + 8'h01;
        w_mem_addr_nxt = r_clr_cnt + 8'h01;
        w_mem_en_nxt   = 1'b1;
      end
    end else if (w_clr_go) begin
      w_state_nxt     = ST_CLEAR;
      w_clr_busy_nxt  = 1'b1;
      w_clr_cnt_nxt   = 8'h00;
      w_mem_addr_nxt  = 8'h00;
      w_mem_wdata_nxt = 8'h00;
      w_mem_en_nxt    = 1'b1;
    end else if (w_gnt_dma) begin
      w_state_nxt     = ST_SERVE;
      w_dma_gnt_nxt   = 1'b1;
      w_mem_addr_nxt  = dma_addr;
      w_mem_wdata_nxt = dma_wdata;
      w_mem_en_nxt    = dma_we;
    end else if (w_gnt_cpu) begin
      w_state_nxt     = ST_SERVE;
      w_cpu_gnt_nxt   = 1'b1;
      w_mem_addr_nxt  = cpu_addr;
      w_mem_wdata_nxt = cpu_wdata;
      w_mem_en_nxt    = cpu_we;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (w_gnt_dma || !dma_req) begin
      w_starve_cnt_nxt = '0;
    end else if (w_gnt_cpu && !w_starved) begin
      w_starve_cnt_nxt = r_starve_cnt + SCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_cpu_valid  <= 1'b0;
      r_dma_valid  <= 1'b0;
      r_cpu_rdata  <= 8'h00;
      r_dma_rdata  <= 8'h00;
      r_clr_busy   <= 1'b0;
      r_clr_cnt    <= 8'h00;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= 8'h00;
      r_mem_wdata  <= 8'h00;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_gnt    <= w_cpu_gnt_nxt;
      r_dma_gnt    <= w_dma_gnt_nxt;
      r_cpu_valid  <= w_cpu_rd_ret;
      r_dma_valid  <= w_dma_rd_ret;
      if (w_cpu_rd_ret) r_cpu_rdata <= mem_rdata;
      if (w_dma_rd_ret) r_dma_rdata <= mem_rdata;
      r_clr_busy   <= w_clr_busy_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  assign cpu_gnt   = r_cpu_gnt;
  assign dma_gnt   = r_dma_gnt;
  assign cpu_valid = r_cpu_valid;
  assign dma_valid = r_dma_valid;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign clr_busy  = r_clr_busy;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: read expectations are queued at issue and
// popped by a monitor on each cpu_valid/dma_valid; directed checks cover the rest.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, dma_req, dma_we, clr_start;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic       cpu_gnt, cpu_valid, dma_gnt, dma_valid, clr_busy, mem_en;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] cpu_q[$];
  logic [7:0] dma_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_dma_gnt = 0;
  logic       prev_cpu_rd = 1'b0;
  logic       prev_dma_rd = 1'b0;
  logic       cur_we;
  logic [7:0] cur_addr, cur_wdata;

  dmem_arbiter #(.CPU_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_valid(dma_valid),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: write at the end of the enabled cycle, combinational read.
  initial for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
  always @(posedge clk) if (mem_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_cpu_rd <= 1'b0;
      prev_dma_rd <= 1'b0;
    end else begin
      if (dma_gnt) n_dma_gnt <= n_dma_gnt + 1;
      if (cpu_valid) begin
        check("cpu_rd_latency", prev_cpu_rd, 1);
        if (cpu_q.size() == 0) check("cpu_unexpected_valid", cpu_q.size(), 1);
        else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (dma_valid) begin
        check("dma_rd_latency", prev_dma_rd, 1);
        if (dma_q.size() == 0) check("dma_unexpected_valid", dma_q.size(), 1);
        else check("dma_rdata", dma_rdata, dma_q.pop_front());
      end
      prev_cpu_rd <= cpu_gnt & ~mem_en;
      prev_dma_rd <= dma_gnt & ~mem_en;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_cpu_gnt"}, cpu_gnt, 0);
    check({tag, "_dma_gnt"}, dma_gnt, 0);
    check({tag, "_cpu_valid"}, cpu_valid, 0);
    check({tag, "_dma_valid"}, dma_valid, 0);
    check({tag, "_clr_busy"}, clr_busy, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dma_rdata"}, dma_rdata, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit is_dma, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd);
    cur_we = we; cur_addr = addr; cur_wdata = wdata;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      if (!we) dma_q.push_back(exp_rd);
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      if (!we) cpu_q.push_back(exp_rd);
    end
  endtask

  task automatic wait_gnt(input bit is_dma, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (is_dma ? dma_gnt : cpu_gnt) got = 1'b1;
    end
    check({name, "_gnt"}, got, 1);
    if (got) begin
      check({name, "_mem_addr"}, mem_addr, cur_addr);
      check({name, "_mem_en"}, mem_en, cur_we);
      if (cur_we) check({name, "_mem_wdata"}, mem_wdata, cur_wdata);
    end
    if (is_dma) dma_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic access(input bit is_dma, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd, input string name);
    issue(is_dma, we, addr, wdata, exp_rd);
    wait_gnt(is_dma, name);
  endtask

  // Starts a clear from a sample point; optionally re-pulses clr_start or
  // asserts reset at a given busy cycle (0 = never).
  task automatic run_clear(input int again_at, input int rst_at,
                           output int busy, output int gnt_in);
    bit done = 1'b0;
    busy = 0; gnt_in = 0;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    check("clr_busy_rise", clr_busy, 1);
    for (int i = 0; i < 300 && clr_busy && !done; i++) begin
      busy++;
      if (cpu_gnt || dma_gnt) gnt_in++;
      if (busy == 1) check("clr_first_addr", mem_addr, 8'h00);
      if (busy == 1) check("clr_mem_en", mem_en, 1);
      if (busy == 256) check("clr_last_addr", mem_addr, 8'hFF);
      if (busy == 256) check("clr_wdata", mem_wdata, 8'h00);
      if (busy == rst_at) begin
        #1 rst = 1'b1;
        #1 check_reset("mid_clr_rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        done = 1'b1;
      end else begin
        clr_start = (busy == again_at);
        @(posedge clk); #1;
      end
    end
    clr_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, gin, d0, viol;
    int pat[$];
    int exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic pc, pd;

    rst = 1'b1; clr_start = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    #3 check_reset("por");
    idle(2);
    rst = 1'b0;
    idle(2);

    // CPU write then read-back; no DMA activity.
    d0 = n_dma_gnt;
    access(0, 1, 8'h10, 8'hA5, 8'h00, "cpu_wr10");
    access(0, 0, 8'h10, 8'h00, 8'hA5, "cpu_rd10");
    idle(3);
    check("no_dma_gnt", n_dma_gnt - d0, 0);

    // Both requesters held: expect C,C,C,C,D repeating, never same port twice in a row.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h41; cpu_wdata = 8'h22;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h11;
    viol = 0; pc = 1'b0; pd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cpu_gnt) pat.push_back(0);
      if (dma_gnt) pat.push_back(1);
      if ((cpu_gnt && (pc || dma_gnt)) || (dma_gnt && pd)) viol++;
      pc = cpu_gnt; pd = dma_gnt;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check("burst_grant_count", pat.size() >= 10, 1);
    for (int i = 0; i < 10 && i < pat.size(); i++) check("burst_pattern", pat[i], exp_pat[i]);
    check("burst_back_to_back", viol, 0);
    idle(3);

    // Full clear with a CPU read raised on the same edge as clr_start.
    access(0, 1, 8'h00, 8'h5A, 8'h00, "cpu_wr00");
    access(0, 1, 8'hFF, 8'h5A, 8'h00, "cpu_wrff");
    idle(1);
    issue(0, 0, 8'h00, 8'h00, 8'h00);
    run_clear(0, 0, busy, gin);
    check("clr_busy_cycles", busy, 256);
    check("clr_no_gnt", gin, 0);
    wait_gnt(0, "cpu_rd00_after_clr");
    access(0, 0, 8'hFF, 8'h00, 8'h00, "cpu_rdff");
    idle(3);

    // Second clr_start during clear is ignored.
    run_clear(100, 0, busy, gin);
    check("clr_again_busy_cycles", busy, 256);
    idle(3);

    // Reset mid-clear: earlier content past the cleared region survives.
    access(0, 1, 8'h80, 8'h77, 8'h00, "cpu_wr80");
    access(0, 1, 8'h10, 8'h33, 8'h00, "cpu_wr10b");
    idle(1);
    run_clear(0, 50, busy, gin);
    idle(2);
    access(0, 0, 8'h80, 8'h00, 8'h77, "cpu_rd80_after_rst");
    access(0, 0, 8'h10, 8'h00, 8'h00, "cpu_rd10_after_rst");
    idle(3);

    // DMA read raised with clr_start: served after the clear.
    issue(1, 0, 8'h80, 8'h00, 8'h00);
    run_clear(0, 0, busy, gin);
    check("clr_dma_busy_cycles", busy, 256);
    check("clr_dma_no_gnt", gin, 0);
    wait_gnt(1, "dma_rd80_after_clr");
    access(0, 1, 8'h80, 8'hC3, 8'h00, "cpu_wr80b");
    access(1, 0, 8'h80, 8'h00, 8'hC3, "dma_rd80");
    idle(4);

    check("cpu_q_drained", cpu_q.size(), 0);
    check("dma_q_drained", dma_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
